// File: rtl/fetch_queue.sv
// Fetch queue: owns the fetch PC, issues one request at a time to the fetcher and
// buffers returned {pc, instr} pairs in a circular FIFO for the decoder. DEPTH must be a power of 2, >= 2.
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 8,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0060
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     fetch_req,
  output logic [DATA_W-1:0]        fetch_pc,
  input  logic                     fetch_rdy,
  input  logic [DATA_W-1:0]        fetch_instr,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        flush_pc,
  input  logic                     deq,
  output logic                     valid,
  output logic [DATA_W-1:0]        instr_out,
  output logic [DATA_W-1:0]        pc_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0]   r_req_pc;
  logic [DATA_W-1:0]   w_req_pc_nxt;
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_nxt;
  logic                w_enq;
  logic                w_pop;
  logic [DATA_W-1:0]   r_instr_mem [DEPTH];
  logic [DATA_W-1:0]   r_pc_mem    [DEPTH];

  // Sequential fetch address; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

  always_comb begin
    w_enq       = (r_state == S_REQ) && fetch_rdy && !flush;
    w_pop       = deq && (r_count != '0) && !flush;
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_enq && !w_pop)
      w_count_nxt = r_count + CNT_ONE;
    else if (!w_enq && w_pop)
      w_count_nxt = r_count - CNT_ONE;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_pc_nxt = flush_pc;
        end else if (r_count < DEPTH_C) begin
          w_req_pc_nxt = r_pc;
          w_state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        if (fetch_rdy) begin
          if (flush) begin
            w_pc_nxt    = flush_pc;
            w_state_nxt = S_IDLE;
          end else begin
            w_pc_nxt = pc_inc(r_req_pc);
            if (w_count_nxt < DEPTH_C)
              w_req_pc_nxt = pc_inc(r_req_pc);
            else
              w_state_nxt = S_IDLE;
          end
        end else if (flush) begin
          // The fetcher still owes a response; keep the request up and drop it on arrival.
          w_pc_nxt    = flush_pc;
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (flush)
          w_pc_nxt = flush_pc;
        if (fetch_rdy)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_count  <= w_count_nxt;
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq)
          r_tail <= r_tail + PTR_ONE;
        if (w_pop)
          r_head <= r_head + PTR_ONE;
      end
    end
  end

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_instr_mem[r_tail] <= fetch_instr;
      r_pc_mem[r_tail]    <= r_req_pc;
    end
  end

  assign fetch_req = (r_state != S_IDLE);
  assign fetch_pc  = r_req_pc;
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == DEPTH_C);
  assign valid     = !empty;
  assign instr_out = r_instr_mem[r_head];
  assign pc_out    = r_pc_mem[r_head];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: plays the fetcher and decoder, predicts behaviour with a queue-based model,
// and compares popped head entries through a separate scoreboard monitor.
module tb_fetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_rdy;
  logic [31:0] fetch_instr;
  logic        flush;
  logic [31:0] flush_pc;
  logic        deq;
  logic        valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  fetch_queue #(.DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0060)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_rdy(fetch_rdy), .fetch_instr(fetch_instr), .flush(flush), .flush_pc(flush_pc),
    .deq(deq), .valid(valid), .instr_out(instr_out), .pc_out(pc_out),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_exp_req;
  bit          m_held;
  bit          m_stale;
  logic [31:0] m_held_pc;
  logic [31:0] m_next_pc;
  int          m_pre_size;
  int          m_step_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of fetcher/decoder activity; entered and left on a falling edge.
  task automatic step(input bit rdy, input bit fl, input logic [31:0] flpc, input bit dq, input bit xor_mode);
    logic [31:0] cur_pc;
    logic [31:0] ins;
    int          pre;
    int          after;
    bit          push;
    bit          pop;
    chk("fetch_req", fetch_req, m_exp_req);
    cur_pc = m_held ? m_held_pc : m_next_pc;
    if (m_exp_req) chk("fetch_pc", fetch_pc, cur_pc);
    chk("count", count, q.size());
    chk("valid", valid, q.size() != 0);
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);

    pre  = q.size();
    ins  = xor_mode ? (cur_pc ^ 32'h0000_FFFF) : $urandom;
    fetch_rdy = rdy; flush = fl; flush_pc = flpc; deq = dq; fetch_instr = ins;
    m_pre_size = pre;
    m_step_id++;

    push  = m_exp_req && rdy && !fl && !m_stale;
    pop   = dq && !fl && (pre > 0);
    after = fl ? 0 : pre + int'(push) - int'(pop);

    if (m_exp_req) begin
      if (rdy) begin
        if (push) m_next_pc = cur_pc + 32'd4;
        if (fl)   m_next_pc = flpc;
        m_exp_req = push && (after < DEPTH);
        m_held    = 1'b0;
        m_stale   = 1'b0;
      end else begin
        if (fl) begin
          m_next_pc = flpc;
          m_stale   = 1'b1;
        end
        m_held    = 1'b1;
        m_held_pc = cur_pc;
      end
    end else begin
      if (fl) m_next_pc = flpc;
      m_exp_req = !fl && (pre < DEPTH);
    end

    if (fl) q.delete();
    else if (push) q.push_back('{pc: cur_pc, ins: ins});
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; entered on a falling edge, released on a later one.
  task automatic do_reset();
    #3;
    rst = 1'b1; fetch_rdy = 1'b0; flush = 1'b0; deq = 1'b0; flush_pc = '0; fetch_instr = '0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_fetch_pc", fetch_pc, 32'h60);
    chk("rst_valid", valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_exp_req = 1'b0; m_next_pc = 32'h60; m_held = 1'b0; m_stale = 1'b0;
  endtask

  // Scoreboard monitor: a decoder pop retires the oldest expected entry.
  initial begin
    int seen;
    ent_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      #1;
      if (m_step_id != seen) begin
        seen = m_step_id;
        if (deq && !flush && (m_pre_size > 0)) begin
          e = q.pop_front();
          chk("pc_out", pc_out, e.pc);
          chk("instr_out", instr_out, e.ins);
        end
      end
    end
  end

  initial begin
    logic [31:0] fpc;
    rst = 1'b1; fetch_rdy = 1'b0; flush = 1'b0; deq = 1'b0; flush_pc = '0; fetch_instr = '0;
    @(negedge clk);
    do_reset();

    // Fill from reset with rdy tied high.
    repeat (11) step(1, 0, 0, 0, 1);
    chk("t1_count", count, 8);
    chk("t1_full", full, 1);
    chk("t1_fetch_req", fetch_req, 0);
    chk("t1_head_pc", pc_out, 32'h60);
    chk("t1_head_instr", instr_out, 32'h60 ^ 32'hFFFF);

    // One pop on a full queue refills it with 0x80.
    step(1, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    chk("t2_count", count, 8);
    chk("t2_head_pc", pc_out, 32'h64);

    // Delayed response.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    chk("t3_count", count, 8);

    // Flush while waiting; the late response is discarded.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h200, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t4_count", count, 0);
    chk("t4_fetch_req", fetch_req, 1);
    chk("t4_fetch_pc", fetch_pc, 32'h200);

    // Flush with coincident rdy and deq on three entries, then a double flush in DISCARD.
    repeat (3) step(1, 0, 0, 0, 1);
    chk("t5_count3", count, 3);
    step(1, 1, 32'h300, 1, 1);
    chk("t5_count0", count, 0);
    step(0, 0, 0, 0, 1);
    chk("t5_fetch_pc", fetch_pc, 32'h300);
    step(0, 1, 32'h400, 0, 1);
    step(0, 1, 32'h500, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t5_final_pc", fetch_pc, 32'h500);

    // Reset mid-request with five entries.
    repeat (5) step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t6_count5", count, 5);
    do_reset();
    repeat (3) step(1, 0, 0, 0, 1);
    chk("t6_head_pc", pc_out, 32'h60);
    chk("t6_count", count, 2);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 600; i++) begin
      fpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, fpc, $urandom_range(0, 1) == 1, 0);
    end
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
